// File: rtl/call_return_sequencer_pkg.sv
// Shared types for the call/return sequencer: run/trap state and trap-cause codes.
package call_return_sequencer_pkg;

    localparam int AW_DEF = 9;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_OVF     = 2'd1,
        CAUSE_UNF     = 2'd2,
        CAUSE_ILLEGAL = 2'd3
    } cause_t;

endpackage

// File: rtl/call_return_sequencer_stack_depth_tracker.sv
// Up/down occupancy counter mirroring the return-address stack, with full/empty flags.
module stack_depth_tracker
    import call_return_sequencer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
        end else if (push && !pop && !full) begin
            depth <= depth + DW'(1);
        end else if (pop && !push && !empty) begin
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/call_return_sequencer.sv
// PC sequencer driving a small return-address stack; traps on stack misuse
// because the stack itself has no overflow/underflow guard.
module call_return_sequencer
    import call_return_sequencer_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [AW-1:0] TRAP_VEC = {AW{1'b1}},
    localparam int           DW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          is_call,
    input  logic          is_ret,
    input  logic          is_jump,
    input  logic          br_taken,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [AW-1:0] stk_wdata,
    input  logic [AW-1:0] stk_rdata,
    output logic [DW-1:0] depth,
    output logic          trap,
    output logic [1:0]    trap_cause
);

    state_t state;
    cause_t cause;
    logic   full;
    logic   empty;
    logic   active;
    logic   trap_req;
    cause_t trap_kind;

    assign active     = !rst && !stall && (state == ST_RUN);
    assign stk_push   = active && is_call && !is_ret && !full;
    assign stk_pop    = active && is_ret && !is_call && !empty;
    assign stk_wdata  = pc + AW'(1);
    assign trap_cause = cause;

    // Illegal combination outranks underflow, which outranks overflow.
    always_comb begin
        trap_req  = 1'b0;
        trap_kind = CAUSE_NONE;
        if (is_call && is_ret) begin
            trap_req  = 1'b1;
            trap_kind = CAUSE_ILLEGAL;
        end else if (is_ret && empty) begin
            trap_req  = 1'b1;
            trap_kind = CAUSE_UNF;
        end else if (is_call && full) begin
            trap_req  = 1'b1;
            trap_kind = CAUSE_OVF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= ST_RUN;
            trap  <= 1'b0;
            cause <= CAUSE_NONE;
        end else if (state == ST_TRAP) begin
            pc <= TRAP_VEC;
        end else if (!stall) begin
            if (trap_req) begin
                state <= ST_TRAP;
                trap  <= 1'b1;
                cause <= trap_kind;
                pc    <= TRAP_VEC;
            end else if (stk_pop) begin
                pc <= stk_rdata;
            end else if (stk_push || is_jump || br_taken) begin
                pc <= target;
            end else begin
                pc <= stk_wdata;
            end
        end
    end

    stack_depth_tracker #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_depth (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    a_no_push_and_pop : assert property (@(posedge clk) !(stk_push && stk_pop));
    a_depth_bounded   : assert property (@(posedge clk) disable iff (rst) depth <= DW'(DEPTH));

endmodule

// File: tb/tb_call_return_sequencer.sv
// Randomized and directed bench for call_return_sequencer with a behavioural stack and reference model.
module tb_call_return_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       is_call = 1'b0;
    logic       is_ret = 1'b0;
    logic       is_jump = 1'b0;
    logic       br_taken = 1'b0;
    logic [8:0] target = '0;
    logic [8:0] pc;
    logic       stk_push;
    logic       stk_pop;
    logic [8:0] stk_wdata;
    logic [8:0] stk_rdata;
    logic [1:0] depth;
    logic       trap;
    logic [1:0] trap_cause;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    call_return_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .is_call    (is_call),
        .is_ret     (is_ret),
        .is_jump    (is_jump),
        .br_taken   (br_taken),
        .target     (target),
        .pc         (pc),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .stk_wdata  (stk_wdata),
        .stk_rdata  (stk_rdata),
        .depth      (depth),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    // Behavioural 2-entry stack attached to the strobes; empty slot reads stale data.
    logic [8:0] smem [2];
    int         sp = 0;

    always @(posedge clk) begin
        if (rst) begin
            sp <= 0;
        end else if (stk_push && sp < 2) begin
            smem[sp] <= stk_wdata;
            sp       <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    assign stk_rdata = (sp > 0) ? smem[sp-1] : 9'h0AA;

    // Reference model
    logic [8:0] m_pc = '0;
    logic [8:0] m_q[$];
    logic       m_trap = 1'b0;
    logic [1:0] m_cause = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_trap(input logic [1:0] c);
        m_trap  = 1'b1;
        m_cause = c;
        m_pc    = 9'h1FF;
    endtask

    task automatic cyc(input bit r, input bit s, input bit c, input bit rt,
                       input bit j, input bit b, input logic [8:0] tg);
        bit         ep;
        bit         eo;
        logic [8:0] ra;
        @(negedge clk);
        rst = r; stall = s; is_call = c; is_ret = rt;
        is_jump = j; br_taken = b; target = tg;
        #1;
        ep = 1'b0;
        eo = 1'b0;
        ra = m_pc + 9'd1;
        if (!r && !s && !m_trap && !(c && rt)) begin
            if (rt)     eo = (m_q.size() > 0);
            else if (c) eo = 1'b0;
            if (!rt && c) ep = (m_q.size() < 2);
        end
        check("push", stk_push, ep);
        check("pop", stk_pop, eo);
        check("wdata", stk_wdata, ra);
        @(posedge clk);
        if (r) begin
            m_pc = 9'd0; m_q.delete(); m_trap = 1'b0; m_cause = 2'd0;
        end else if (!m_trap && !s) begin
            if (c && rt)            model_trap(2'd3);
            else if (rt) begin
                if (m_q.size() == 0) model_trap(2'd2);
                else                 m_pc = m_q.pop_back();
            end else if (c) begin
                if (m_q.size() == 2) model_trap(2'd1);
                else begin
                    m_q.push_back(ra);
                    m_pc = tg;
                end
            end else if (j || b)    m_pc = tg;
            else                    m_pc = ra;
        end
        #1;
        check("pc", pc, m_pc);
        check("depth", depth, m_q.size());
        check("trap", trap, m_trap);
        check("cause", trap_cause, m_cause);
    endtask

    initial begin
        // reset and sequential run
        cyc(1, 0, 0, 0, 0, 0, 9'h0);
        check("rst_pc", pc, 9'h000);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 9'h0);
        check("idle_pc", pc, 9'h004);
        cyc(0, 0, 0, 0, 0, 0, 9'h0);
        // nested call / return
        cyc(0, 0, 1, 0, 0, 0, 9'h040);
        check("call1_pc", pc, 9'h040);
        cyc(0, 0, 0, 0, 0, 0, 9'h0);
        cyc(0, 0, 1, 0, 0, 0, 9'h080);
        check("call2_depth", depth, 2);
        cyc(0, 0, 0, 1, 0, 0, 9'h0);
        check("ret1_pc", pc, 9'h042);
        cyc(0, 0, 0, 1, 0, 0, 9'h0);
        check("ret2_pc", pc, 9'h006);
        // overflow trap then stuck
        cyc(0, 0, 1, 0, 0, 0, 9'h010);
        cyc(0, 0, 1, 0, 0, 0, 9'h020);
        cyc(0, 0, 1, 0, 0, 0, 9'h030);
        check("ovf_cause", trap_cause, 2'd1);
        cyc(0, 0, 1, 0, 0, 0, 9'h011);
        cyc(0, 0, 0, 1, 0, 0, 9'h0);
        cyc(0, 0, 0, 0, 1, 0, 9'h022);
        check("trap_hold_pc", pc, 9'h1FF);
        cyc(1, 0, 0, 0, 0, 0, 9'h0);
        check("rst_cause", trap_cause, 2'd0);
        // underflow
        cyc(0, 0, 0, 1, 0, 0, 9'h0);
        check("unf_cause", trap_cause, 2'd2);
        cyc(1, 0, 0, 0, 0, 0, 9'h0);
        // illegal call+ret with one entry on the stack
        cyc(0, 0, 1, 0, 0, 0, 9'h050);
        cyc(0, 0, 1, 1, 0, 0, 9'h060);
        check("ill_cause", trap_cause, 2'd3);
        check("ill_depth", depth, 1);
        cyc(1, 0, 0, 0, 0, 0, 9'h0);
        // wraparound
        cyc(0, 0, 0, 0, 1, 0, 9'h1FF);
        cyc(0, 0, 0, 0, 0, 0, 9'h0);
        check("wrap_pc", pc, 9'h000);
        cyc(0, 0, 0, 0, 0, 1, 9'h1FF);
        cyc(0, 0, 1, 0, 0, 0, 9'h020);
        cyc(0, 0, 0, 1, 0, 0, 9'h0);
        check("wrap_ret_pc", pc, 9'h000);
        // stall during call, then reset together with call
        repeat (3) cyc(0, 1, 1, 0, 0, 0, 9'h070);
        check("stall_pc", pc, 9'h000);
        cyc(0, 0, 1, 0, 0, 0, 9'h070);
        check("unstall_depth", depth, 1);
        cyc(1, 0, 1, 0, 0, 0, 9'h090);
        check("rst_call_pc", pc, 9'h000);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(99) < (m_trap ? 25 : 2),
                $urandom_range(99) < 15,
                $urandom_range(99) < 25,
                $urandom_range(99) < 22,
                $urandom_range(99) < 10,
                $urandom_range(99) < 10,
                9'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/call_return_sequencer.md
Name: call_return_sequencer

Overview:
- Program-counter sequencer and initiator side of the 2-entry return-address stack (push/pop/in/out interface).
- Owns the PC register and decodes control-flow events (sequential, jump, taken branch, CALL, RET) into the next PC.
- On CALL, drives push with the return address. On RET, drives pop and loads the PC from the stack top.
- Tracks stack occupancy. Traps on overflow, underflow or an illegal CALL+RET in the same cycle, because the stack itself has no guard.

Parameters:
- AW, 9, PC / return-address width; must match the stack data width.
- DEPTH, 2, stack capacity in entries.
- RESET_PC, 0, PC value loaded on reset.
- TRAP_VEC, 9'h1FF, PC value forced while in TRAP.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  1  hold PC and stack; all control-flow inputs ignored
- is_call  in  1  current instruction is CALL to target
- is_ret  in  1  current instruction is RET
- is_jump  in  1  unconditional jump to target
- br_taken  in  1  conditional branch resolved taken to target
- target  in  AW  jump/branch/call destination
- pc  out  AW  current program counter (registered)
- stk_push  out  1  stack push strobe (combinational)
- stk_pop  out  1  stack pop strobe (combinational)
- stk_wdata  out  AW  data to stack "in" = pc+1
- stk_rdata  in  AW  stack "out" (top of stack; valid combinationally)
- depth  out  $clog2(DEPTH+1)  current occupancy (registered)
- trap  out  1  high while in TRAP state
- trap_cause  out  2  0 NONE, 1 OVF, 2 UNF, 3 ILLEGAL (registered, sticky until rst)

Behaviour:
- Reset: on rst at a rising edge, pc=RESET_PC, depth=0, state=RUN, trap=0, trap_cause=NONE. stk_push=stk_pop=0 during rst. rst overrides every other input. The stack has no reset, so its contents are stale and treated as empty.
- States: RUN, TRAP.
- RUN next-PC priority, evaluated each cycle with stall=0:
  1. is_call&&is_ret: go to TRAP, cause=ILLEGAL, no push/pop.
  2. is_ret, depth==0: go to TRAP, cause=UNF, no pop.
  3. is_ret, depth>0: stk_pop=1, pc<=stk_rdata, depth<=depth-1.
  4. is_call, depth==DEPTH: go to TRAP, cause=OVF, no push.
  5. is_call, depth<DEPTH: stk_push=1, stk_wdata=pc+1, pc<=target, depth<=depth+1.
  6. is_jump or br_taken: pc<=target.
  7. Otherwise: pc<=pc+1.
- All PC arithmetic is modulo 2^AW; pc=2^AW-1 wraps to 0. The return address pc+1 wraps the same way.
- Latency: one cycle from event to new pc. Push and pop take effect at the same edge as the pc update. A RET immediately after a CALL returns the value just pushed.
- stk_push and stk_pop are never both 1 (assertion). Both are 0 whenever stall=1, state=TRAP or rst=1.
- stall=1: pc, depth and state hold; no strobes.
- TRAP: entry edge sets pc<=TRAP_VEC and trap=1. pc holds TRAP_VEC and all inputs are ignored until rst. trap_cause records the first cause only.
- depth never exceeds DEPTH and never goes below 0 (assertion).

Decomposition:
- Shared package: state enum (RUN, TRAP) and trap-cause constants (NONE/OVF/UNF/ILLEGAL).
- AW defaults are shared with the stack.
- One natural sub-module: stack_depth_tracker, an up/down occupancy counter with full/empty flags driven by the push/pop strobes.

Test Plan:
- Reset then 4 idle cycles: pc 0,1,2,3,4; depth 0; no strobes.
- At pc=5, CALL target=0x40: push with wdata=6, pc=0x40, depth=1. At pc=0x41, CALL 0x80: wdata=0x42, depth=2. RET: pop, pc=0x42, depth=1. RET: pop, pc=6, depth=0. Run with the real stack instance attached.
- depth=2, CALL 0x10: no push, pc=0x1FF, trap=1, cause=OVF. Further CALL/RET/jump: pc stays 0x1FF. rst: pc=0, cause=NONE.
- After reset, RET: no pop, trap, cause=UNF. Separately, CALL+RET in the same cycle: cause=ILLEGAL, depth unchanged.
- pc=0x1FF in RUN, then sequential: pc=0. CALL at pc=0x1FF: stk_wdata=0.
- stall held 3 cycles during CALL: pc, depth unchanged, no push. stall released: push occurs once. rst asserted together with CALL: no push, pc=0.
